// File: rtl/pause_pkg.sv
// Shared types and defaults for the pause / screen-dim controller.
package pause_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LIT  = 2'd1,
    FADE = 2'd2,
    DIM  = 2'd3
  } state_t;

  localparam logic [1:0] DIM_OFF = 2'd0;

  localparam int unsigned DIM_CYCLES_DEF  = 180000000;
  localparam int unsigned FADE_CYCLES_DEF = 4500000;

endpackage

// File: rtl/pause_dim_ctrl_rgb_dimmer.sv
// Registered RGB right-shift dimmer, updated only on pixel clock enable.
module rgb_dimmer #(
  parameter int unsigned R_W = 3,
  parameter int unsigned G_W = 3,
  parameter int unsigned B_W = 2
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  input  logic           ce_pix,
  input  logic [1:0]     shift,
  input  logic [R_W-1:0] r_in,
  input  logic [G_W-1:0] g_in,
  input  logic [B_W-1:0] b_in,
  output logic [R_W-1:0] r_out,
  output logic [G_W-1:0] g_out,
  output logic [B_W-1:0] b_out
);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_out <= '0;
      g_out <= '0;
      b_out <= '0;
    end else if (ce_pix) begin
      r_out <= r_in >> shift;
      g_out <= g_in >> shift;
      b_out <= b_in >> shift;
    end
  end

endmodule

// File: rtl/pause_dim_ctrl.sv
// Combines pause sources into one registered pause and fades video during long user pauses.
module pause_dim_ctrl
  import pause_pkg::*;
#(
  parameter int unsigned NSRC        = 2,
  parameter int unsigned R_W         = 3,
  parameter int unsigned G_W         = 3,
  parameter int unsigned B_W         = 2,
  parameter int unsigned DIM_CYCLES  = DIM_CYCLES_DEF,
  parameter int unsigned FADE_CYCLES = FADE_CYCLES_DEF,
  parameter int unsigned TW          = 32
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            pause_btn,
  input  logic [NSRC-1:0] pause_src,
  input  logic            osd_open,
  input  logic            osd_pause_en,
  input  logic [1:0]      dim_max,
  input  logic            ce_pix,
  input  logic [R_W-1:0]  r_in,
  input  logic [G_W-1:0]  g_in,
  input  logic [B_W-1:0]  b_in,
  output logic            pause,
  output logic            user_paused,
  output logic [1:0]      dim_level,
  output logic [R_W-1:0]  r_out,
  output logic [G_W-1:0]  g_out,
  output logic [B_W-1:0]  b_out
);

  localparam logic [TW-1:0] DIM_LAST  = TW'(DIM_CYCLES - 1);
  localparam logic [TW-1:0] FADE_LAST = TW'(FADE_CYCLES - 1);

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [1:0]    lvl, lvl_nx;
  logic          btn_prev, up, up_nx, rise;

  always_comb begin
    rise     = pause_btn & ~btn_prev;
    up_nx    = up ^ rise;
    state_nx = state;
    timer_nx = timer;
    lvl_nx   = lvl;
    // A toggle edge overrides any timer or fade step in the same cycle.
    if (rise) begin
      state_nx = up ? RUN : LIT;
      timer_nx = '0;
      lvl_nx   = '0;
    end else begin
      case (state)
        RUN: begin
          timer_nx = '0;
          lvl_nx   = '0;
        end
        LIT: begin
          if (timer == DIM_LAST) begin
            if (dim_max != DIM_OFF) begin
              timer_nx = '0;
              lvl_nx   = 2'd1;
              state_nx = (dim_max == 2'd1) ? DIM : FADE;
            end
          end else begin
            timer_nx = timer + 1'b1;
          end
        end
        FADE: begin
          if (dim_max == DIM_OFF) begin
            state_nx = LIT;
            timer_nx = DIM_LAST;
            lvl_nx   = '0;
          end else if (lvl >= dim_max) begin
            state_nx = DIM;
            timer_nx = '0;
            lvl_nx   = dim_max;
          end else if (timer == FADE_LAST) begin
            timer_nx = '0;
            lvl_nx   = 2'(lvl + 2'd1);
            if (2'(lvl + 2'd1) == dim_max) state_nx = DIM;
          end else begin
            timer_nx = timer + 1'b1;
          end
        end
        DIM: begin
          // Returning to LIT with a saturated timer lets a later non-zero dim_max fade at once.
          if (dim_max == DIM_OFF) begin
            state_nx = LIT;
            timer_nx = DIM_LAST;
            lvl_nx   = '0;
          end else if (dim_max > lvl) begin
            state_nx = FADE;
            timer_nx = '0;
          end else if (dim_max < lvl) begin
            lvl_nx = dim_max;
          end
        end
        default: begin
          state_nx = RUN;
          timer_nx = '0;
          lvl_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      btn_prev <= 1'b0;
      up       <= 1'b0;
      pause    <= 1'b0;
      state    <= RUN;
      timer    <= '0;
      lvl      <= '0;
    end else begin
      btn_prev <= pause_btn;
      up       <= up_nx;
      pause    <= up_nx | (|pause_src) | (osd_open & osd_pause_en);
      state    <= state_nx;
      timer    <= timer_nx;
      lvl      <= lvl_nx;
    end
  end

  assign user_paused = up;
  assign dim_level   = lvl;

  rgb_dimmer #(
    .R_W(R_W),
    .G_W(G_W),
    .B_W(B_W)
  ) u_dimmer (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .ce_pix (ce_pix),
    .shift  (lvl),
    .r_in   (r_in),
    .g_in   (g_in),
    .b_in   (b_in),
    .r_out  (r_out),
    .g_out  (g_out),
    .b_out  (b_out)
  );

endmodule

// File: tb/tb_pause_dim_ctrl.sv
// Directed scoreboard bench for pause_dim_ctrl with short dim/fade intervals.
module tb_pause_dim_ctrl;

  localparam int unsigned NSRC = 2;
  localparam int SIG_PAUSE = 0, SIG_UP = 1, SIG_DIM = 2, SIG_R = 3, SIG_G = 4, SIG_B = 5;

  logic            clk_sys = 1'b0;
  logic            reset_n;
  logic            pause_btn;
  logic [NSRC-1:0] pause_src;
  logic            osd_open, osd_pause_en;
  logic [1:0]      dim_max;
  logic            ce_pix;
  logic [2:0]      r_in, g_in;
  logic [1:0]      b_in;
  logic            pause, user_paused;
  logic [1:0]      dim_level;
  logic [2:0]      r_out, g_out;
  logic [1:0]      b_out;

  typedef struct {
    string      tag;
    int         sig;
    logic [7:0] exp;
  } item_t;

  item_t sb[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  pause_dim_ctrl #(
    .NSRC(NSRC), .R_W(3), .G_W(3), .B_W(2),
    .DIM_CYCLES(100), .FADE_CYCLES(10), .TW(32)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .pause_btn(pause_btn),
    .pause_src(pause_src), .osd_open(osd_open), .osd_pause_en(osd_pause_en),
    .dim_max(dim_max), .ce_pix(ce_pix),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .pause(pause), .user_paused(user_paused), .dim_level(dim_level),
    .r_out(r_out), .g_out(g_out), .b_out(b_out)
  );

  function automatic logic [7:0] observe(input int sig);
    case (sig)
      SIG_PAUSE: return {7'd0, pause};
      SIG_UP:    return {7'd0, user_paused};
      SIG_DIM:   return {6'd0, dim_level};
      SIG_R:     return {5'd0, r_out};
      SIG_G:     return {5'd0, g_out};
      default:   return {6'd0, b_out};
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input int exp);
    item_t it;
    it.tag = tag;
    it.sig = sig;
    it.exp = 8'(exp);
    sb.push_back(it);
  endtask

  task automatic push_rgb(input string tag, input int r, input int g, input int b);
    push({tag, "_r"}, SIG_R, r);
    push({tag, "_g"}, SIG_G, g);
    push({tag, "_b"}, SIG_B, b);
  endtask

  task automatic drain();
    item_t      it;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      obs = observe(it.sig);
      n_assert++;
      assert (obs === it.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%0d expected=%0d", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
    drain();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset_n = 1'b0; pause_btn = 1'b0; pause_src = '0;
    osd_open = 1'b0; osd_pause_en = 1'b0; dim_max = 2'd3; ce_pix = 1'b1;
    r_in = 3'b111; g_in = 3'b111; b_in = 2'b11;

    // Reset state
    push("rst_pause", SIG_PAUSE, 0); push("rst_up", SIG_UP, 0); push("rst_dim", SIG_DIM, 0);
    push_rgb("rst", 0, 0, 0);
    step();
    reset_n = 1'b1;
    push("idle_pause", SIG_PAUSE, 0); push("idle_dim", SIG_DIM, 0);
    push_rgb("idle", 7, 7, 3);
    step();

    // External pause: one cycle late, exactly as long as the request, never dims
    pause_src = 2'b10;
    for (int i = 0; i < 5; i++) begin
      push("src_pause_hi", SIG_PAUSE, 1);
      step();
    end
    pause_src = '0;
    push("src_pause_lo", SIG_PAUSE, 0);
    step();
    pause_src = 2'b01;
    run(199);
    push("src_long_pause", SIG_PAUSE, 1); push("src_long_dim", SIG_DIM, 0); push("src_long_up", SIG_UP, 0);
    step();
    pause_src = '0;
    push("src_release", SIG_PAUSE, 0);
    step();

    // User pause and fade to level 3
    pause_btn = 1'b1;
    push("btn_pause", SIG_PAUSE, 1); push("btn_up", SIG_UP, 1);
    step();
    pause_btn = 1'b0;
    run(98);
    push("lit_e99_dim", SIG_DIM, 0); step();
    push("lit_e100_dim", SIG_DIM, 1); step();
    push("l1_dim", SIG_DIM, 1); push_rgb("l1", 3, 3, 1); step();
    run(7);
    push("fade_e109_dim", SIG_DIM, 1); step();
    push("fade_e110_dim", SIG_DIM, 2); step();
    push_rgb("l2", 1, 1, 0); step();
    run(7);
    push("fade_e119_dim", SIG_DIM, 2); step();
    push("fade_e120_dim", SIG_DIM, 3); step();
    push_rgb("l3", 0, 0, 0); step();
    run(19);
    push("dim_hold", SIG_DIM, 3); push("dim_hold_pause", SIG_PAUSE, 1); step();

    // Unpause from DIM
    pause_btn = 1'b1;
    push("unp_up", SIG_UP, 0); push("unp_dim", SIG_DIM, 0); push("unp_pause", SIG_PAUSE, 0);
    step();
    pause_btn = 1'b0;
    push_rgb("unp", 7, 7, 3);
    step();

    // dim_max = 0 disables dimming; raising it resumes from a saturated timer
    dim_max = 2'd0; pause_btn = 1'b1;
    push("nodim_up", SIG_UP, 1);
    step();
    pause_btn = 1'b0;
    run(299);
    push("nodim_dim", SIG_DIM, 0); step();
    dim_max = 2'd2;
    push("raise_dim1", SIG_DIM, 1); step();
    run(8);
    push("raise_e9_dim", SIG_DIM, 1); step();
    push("raise_e10_dim", SIG_DIM, 2); step();
    dim_max = 2'd1;
    push("clamp_dim", SIG_DIM, 1); push_rgb("clamp_prev", 1, 1, 0); step();
    dim_max = 2'd0;
    push("zero_dim", SIG_DIM, 0); step();
    dim_max = 2'd3;
    push("resume_dim", SIG_DIM, 1); step();
    pause_btn = 1'b1;
    push("off2_up", SIG_UP, 0); push("off2_dim", SIG_DIM, 0);
    step();
    pause_btn = 1'b0;

    // OSD pause gating
    osd_open = 1'b1; osd_pause_en = 1'b0;
    push("osd_noen", SIG_PAUSE, 0); step();
    osd_pause_en = 1'b1;
    push("osd_en", SIG_PAUSE, 1); step();
    osd_open = 1'b0; osd_pause_en = 1'b0;
    push("osd_off", SIG_PAUSE, 0); step();

    // Held button toggles once
    pause_btn = 1'b1;
    push("held_up0", SIG_UP, 1); push("held_pause", SIG_PAUSE, 1); step();
    run(48);
    push("held_up49", SIG_UP, 1); step();
    pause_btn = 1'b0;
    push("held_rel_up", SIG_UP, 1); step();
    run(54);
    push("mid_fade_dim", SIG_DIM, 1); step();

    // Asynchronous reset mid-fade
    reset_n = 1'b0;
    #2;
    push("arst_pause", SIG_PAUSE, 0); push("arst_up", SIG_UP, 0); push("arst_dim", SIG_DIM, 0);
    push_rgb("arst", 0, 0, 0);
    drain();
    reset_n = 1'b1;
    push("post_rst_up", SIG_UP, 0); push("post_rst_dim", SIG_DIM, 0);
    push_rgb("post_rst", 7, 7, 3);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
